// File: rtl/dac_spi_tx.sv
// dac_spi_tx: turns Q10.16 filter samples into 12-bit offset-binary codes
// and ships them to a serial DAC as 16-bit frames, MSB first.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   yk         signed Q10.16 filter sample (27 bits)
//   resulisto  sample-valid; each 0->1 transition accepts yk
//   sclk       DAC serial clock (idles high)
//   sync_n     DAC frame select, active-low
//   sdata      DAC serial data, changes with sclk rising
//   busy       frame in progress or sample pending
//   overrun    sticky: a pending sample was replaced before it was sent
module dac_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] yk,
    input  logic        resulisto,
    output logic        sclk,
    output logic        sync_n,
    output logic        sdata,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     half_q, half_d;
    logic [15:0]    sr_q, sr_d;
    logic           sclk_q, sclk_d;
    logic           sync_q, sync_d;
    logic           pend_q, pend_d;
    logic [11:0]    pcode_q, pcode_d;
    logic           ovr_q, ovr_d;
    logic           prev_q;

    logic               accept;
    logic signed [26:0] shifted;
    logic [11:0]        code;
    logic               start;
    logic               store;
    logic [11:0]        start_code;

    assign accept  = resulisto & ~prev_q;
    assign shifted = $signed(yk) >>> 5;

    // Saturate to 12-bit signed, then add 2048 (same as flipping the MSB).
    always_comb begin
        if (shifted > 27'sd2047) begin
            code = 12'hFFF;
        end else if (shifted < -27'sd2048) begin
            code = 12'h000;
        end else begin
            code = {~shifted[11], shifted[10:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        sr_d       = sr_q;
        sclk_d     = sclk_q;
        sync_d     = sync_q;
        pend_d     = pend_q;
        pcode_d    = pcode_q;
        ovr_d      = ovr_q;
        start      = 1'b0;
        store      = 1'b0;
        start_code = code;

        unique case (state_q)
            IDLE: begin
                start = accept;
            end
            SHIFT: begin
                store = accept;
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (half_q == 5'd31) begin
                        state_d = GAP;
                        sync_d  = 1'b1;
                        sclk_d  = 1'b1;
                        sr_d    = '0;
                    end else begin
                        half_d = half_q + 5'd1;
                        sclk_d = ~sclk_q;
                        // next bit appears with sclk rising
                        if (!sclk_q) begin
                            sr_d = {sr_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // A queued frame keeps sync_n high for two half-periods,
                // giving 34 half-periods frame to frame; with nothing
                // queued the gap ends after one half-period.
                if (cnt_q == HALF_END && !pend_q) begin
                    if (accept) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == GAP_END) begin
                    start  = 1'b1;
                    pend_d = 1'b0;
                    if (accept) begin
                        ovr_d = 1'b1;
                    end else begin
                        start_code = pcode_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    store = accept;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (store) begin
            pend_d  = 1'b1;
            pcode_d = code;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
        end

        if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            half_d  = '0;
            sr_d    = {4'b0000, start_code};
            sclk_d  = 1'b1;
            sync_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            pend_q  <= 1'b0;
            pcode_q <= '0;
            ovr_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            pend_q  <= pend_d;
            pcode_q <= pcode_d;
            ovr_q   <= ovr_d;
            prev_q  <= resulisto;
        end
    end

    assign sclk    = sclk_q;
    assign sync_n  = sync_q;
    assign sdata   = sr_q[15];
    assign busy    = (state_q != IDLE) | pend_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: random and directed stimulus for dac_spi_tx; a pin-level
// monitor decodes DAC frames and checks them against queued expectations.
module tb_dac_spi_tx;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [26:0] yk = '0;
    logic        resulisto = 1'b0;
    logic        sclk, sync_n, sdata, busy, overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];

    dac_spi_tx #(.CLK_DIV(D)) dut (
        .clk(clk),
        .reset(reset),
        .yk(yk),
        .resulisto(resulisto),
        .sclk(sclk),
        .sync_n(sync_n),
        .sdata(sdata),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference: floor(yk / 32), saturate to signed 12 bits, offset by 2048.
    function automatic logic [15:0] ref_word(input logic [26:0] y);
        int v;
        int q;
        v = $signed(y);
        if (v >= 0) q = v / 32;
        else q = -((-v + 31) / 32);
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return 16'(q + 2048);
    endfunction

    // Monitor: decode frames from the pins, pop and compare.
    initial begin : mon
        logic sp;
        logic yp;
        logic [15:0] w;
        logic [15:0] e;
        int nb;
        int lc;
        bit inf;
        sp = 1'b1; yp = 1'b1; w = '0; nb = 0; lc = 0; inf = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                inf = 0; sp = 1'b1; yp = 1'b1;
            end else begin
                if (yp && !sync_n) begin
                    inf = 1; w = '0; nb = 0; lc = 0;
                end
                if (inf && !sync_n) begin
                    lc++;
                    if (sp && !sclk) begin
                        w = {w[14:0], sdata};
                        nb++;
                    end
                end
                if (inf && !yp && sync_n) begin
                    inf = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got %0h want none", w);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_word", 32'(w), 32'(e));
                        check("frame_bits", nb, 16);
                        check("sync_low_len", lc, 32 * D);
                    end
                end
                sp = sclk;
                yp = sync_n;
            end
        end
    end

    task automatic pulse(input logic [26:0] v);
        @(negedge clk);
        yk = v;
        resulisto = 1'b1;
        @(negedge clk);
        resulisto = 1'b0;
        yk = 27'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || !sync_n) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || !sync_n) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy want idle");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sync(input logic lvl, input string name);
        int n = 0;
        while (sync_n !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sync_n !== lvl) begin
            total++;
            bad++;
            $display("FAIL %s: got %b want %b", name, sync_n, lvl);
        end
    endtask

    initial begin
        logic [26:0] dv[4];
        logic [15:0] dw[4];
        logic [26:0] a, b, c, v;
        int t1, t2, r;

        dv = '{27'h0010000, 27'h4000000, 27'h7FFFFFF, 27'h0000020};
        dw = '{16'h0FFF, 16'h0000, 16'h07FF, 16'h0801};

        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            yk = 27'($urandom);
            resulisto = 1'($urandom);
            check("reset_outs", {sclk, sync_n, sdata, busy, overrun},
                  5'b11000);
        end
        @(negedge clk);
        resulisto = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        exp_q.push_back(16'h0800);
        pulse(27'h0);
        check("busy_in_frame", busy, 1);
        wait_sync(1'b1, "sync_rise");
        check("busy_at_rise", busy, 1);
        @(negedge clk);
        check("busy_rise_p1", busy, 1);
        @(negedge clk);
        check("busy_rise_p2", busy, 0);
        wait_idle(50);

        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(dw[i]);
            pulse(dv[i]);
            wait_idle(300);
        end

        exp_q.push_back(16'h0800);
        exp_q.push_back(16'h0C00);
        pulse(27'h0);
        t1 = cyc;
        repeat (8) @(negedge clk);
        pulse(27'h0008000);
        wait_sync(1'b1, "b2b_rise");
        wait_sync(1'b0, "b2b_fall");
        t2 = cyc;
        check("b2b_spacing", t2 - t1, 34 * D);
        wait_idle(300);
        check("b2b_overrun", overrun, 0);

        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                v = 27'($urandom);
            end else begin
                r = int'($urandom_range(0, 262143)) - 131072;
                v = 27'(r);
            end
            exp_q.push_back(ref_word(v));
            pulse(v);
            wait_idle(300);
        end

        a = 27'($urandom);
        b = 27'($urandom);
        c = 27'($urandom);
        exp_q.push_back(ref_word(a));
        exp_q.push_back(ref_word(c));
        pulse(a);
        repeat (8) @(negedge clk);
        pulse(b);
        repeat (8) @(negedge clk);
        pulse(c);
        wait_idle(400);
        check("overrun_set", overrun, 1);
        v = 27'($urandom);
        exp_q.push_back(ref_word(v));
        pulse(v);
        wait_idle(300);
        check("overrun_sticky", overrun, 1);

        v = 27'($urandom);
        exp_q.push_back(ref_word(v));
        @(negedge clk);
        yk = v;
        resulisto = 1'b1;
        repeat (150) @(negedge clk);
        check("held_one_accept", busy, 0);
        resulisto = 1'b0;
        wait_idle(300);

        a = 27'($urandom);
        b = 27'($urandom);
        exp_q.push_back(ref_word(a));
        exp_q.push_back(ref_word(b));
        pulse(a);
        t1 = cyc;
        wait_sync(1'b1, "gap_rise");
        repeat (D - 2) @(negedge clk);
        pulse(b);
        t2 = cyc;
        check("gap_direct_start", sync_n, 0);
        check("gap_direct_spacing", t2 - t1, 33 * D);
        wait_idle(300);

        pulse(27'($urandom));
        repeat (16 * D) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_outs", {sclk, sync_n, sdata, busy, overrun}, 5'b11000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_resume", sync_n, 1);
        exp_q.push_back(16'h0800);
        pulse(27'h0);
        wait_idle(300);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
